mux_arb_nw: RTL and testbench

MUX_ARB_NW -- requirements
Module: mux_arb_nw

---
 rtl/mux_arb_nw_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mux_arb_nw.sv | 96 +++++++++
 tb/tb_mux_arb_nw.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nw_pkg.sv
// Shared constants for the mux_arb_nw channel multiplexer/arbiter.
// Mode encodings and default channel geometry.
package mux_arb_nw_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int DEFAULT_N  = 16;
  localparam int DEFAULT_CH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting channel found when scanning from ptr upward,
// wrapping from CH-1 back to 0.
module rr_arbiter
  import mux_arb_nw_pkg::*;
#(
  parameter  int CH = DEFAULT_CH,
  localparam int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int          pos;
  logic [SW-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < CH; i++) begin
      pos = int'(ptr) + i;
      if (pos >= CH) pos = pos - CH;
      idx = SW'(pos);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nw.sv
// CH-input multiplexer with explicit-select or round-robin mode feeding a one-entry output register.
// Optional registered parity output MParity is present when MUX_ARB_NW_PARITY_EN is defined.
module mux_arb_nw
  import mux_arb_nw_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  parameter  int CH = DEFAULT_CH,
  localparam int SW = $clog2(CH)
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Mode,
  input  logic [SW-1:0]   S,
  input  logic [CH*N-1:0] In,
  input  logic [CH-1:0]   InValid,
  output logic [CH-1:0]   InReady,
  output logic [N-1:0]    M,
  output logic            MValid,
  input  logic            MReady,
  output logic [SW-1:0]   MSel
`ifdef MUX_ARB_NW_PARITY_EN
  ,
  output logic            MParity
`endif
);

  logic          le;
  logic          grant;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic [N-1:0]  word;

  rr_arbiter #(.CH(CH)) u_rr_arbiter (
    .req       (InValid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign le = !MValid || MReady;

  always_comb begin
    grant = 1'b0;
    g     = '0;
    if (Mode == MODE_RR) begin
      grant = rr_valid;
      g     = rr_idx;
    end else if (int'(S) < CH && InValid[S]) begin
      grant = 1'b1;
      g     = S;
    end
  end

  always_comb begin
    InReady = '0;
    if (grant) InReady[g] = le;
  end

  assign word     = In[int'(g)*N +: N];
  assign ptr_next = (int'(g) == CH - 1) ? '0 : g + 1'b1;

  always_ff @(posedge Clock or negedge Resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!Resetn) begin
      M      <= '0;
      MSel   <= '0;
      MValid <= 1'b0;
      ptr    <= '0;
    end else if (le) begin
      if (grant) begin
        M      <= word;
        MSel   <= g;
        MValid <= 1'b1;
        if (Mode == MODE_RR) ptr <= ptr_next;
      end else begin
        // Slot drains to empty; data and select keep their last values.
        MValid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_NW_PARITY_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      MParity <= 1'b0;
    end else if (le && grant) begin
      MParity <= ^word;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_nw.sv
// Self-checking bench for mux_arb_nw: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mux_arb_nw;
  import mux_arb_nw_pkg::*;

  localparam int N  = 16;
  localparam int CH = 8;
  localparam int SW = 3;

  logic            Clock = 1'b0;
  logic            Resetn = 1'b0;
  logic            Mode = 1'b0;
  logic [SW-1:0]   S = '0;
  logic [CH*N-1:0] In = '0;
  logic [CH-1:0]   InValid = '0;
  logic            MReady = 1'b0;
  logic [CH-1:0]   InReady;
  logic [N-1:0]    M;
  logic            MValid;
  logic [SW-1:0]   MSel;
`ifdef MUX_ARB_NW_PARITY_EN
  logic            MParity;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 1'b0;

  mux_arb_nw #(.N(N), .CH(CH)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Mode    (Mode),
    .S       (S),
    .In      (In),
    .InValid (InValid),
    .InReady (InReady),
    .M       (M),
    .MValid  (MValid),
    .MReady  (MReady),
    .MSel    (MSel)
`ifdef MUX_ARB_NW_PARITY_EN
    ,
    .MParity (MParity)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Grant from the channel-selection rules: -1 means no grant.
  function automatic int model_grant(logic mode, int s, logic [CH-1:0] v, int p);
    if (mode == MODE_SEL) return (s < CH && v[s]) ? s : -1;
    for (int i = 0; i < CH; i++) begin
      if (v[(p + i) % CH]) return (p + i) % CH;
    end
    return -1;
  endfunction

  // Behavioural model of the output slot.
  logic [N-1:0] m_data = '0;
  int           m_sel  = 0;
  bit           m_valid = 1'b0;
  int           m_ptr  = 0;
  bit           m_par  = 1'b0;
  int           mg;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_data  <= '0;
      m_sel   <= 0;
      m_valid <= 1'b0;
      m_ptr   <= 0;
      m_par   <= 1'b0;
    end else begin
      mg = model_grant(Mode, int'(S), InValid, m_ptr);
      if (!m_valid || MReady) begin
        if (mg >= 0) begin
          m_data  <= In[mg*N +: N];
          m_par   <= ^In[mg*N +: N];
          m_sel   <= mg;
          m_valid <= 1'b1;
          if (Mode == MODE_RR) m_ptr <= (mg + 1) % CH;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  int            cg;
  logic [CH-1:0] exp_rdy;
  always @(negedge Clock) begin
    if (cmp_en) begin
      cg = model_grant(Mode, int'(S), InValid, m_ptr);
      exp_rdy = '0;
      if (cg >= 0 && (!m_valid || MReady)) exp_rdy[cg] = 1'b1;
      check("cmp_in_ready", 64'(InReady), 64'(exp_rdy));
      check("cmp_m_valid", 64'(MValid), 64'(m_valid));
      check("cmp_m", 64'(M), 64'(m_data));
      check("cmp_m_sel", 64'(MSel), 64'(m_sel));
`ifdef MUX_ARB_NW_PARITY_EN
      check("cmp_m_parity", 64'(MParity), 64'(m_par));
`endif
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic set_ch(input int k, input logic [N-1:0] val);
    In[k*N +: N] = val;
  endtask

  int cnt[CH];
  bit all_one;

  initial begin
    // Reset state
    tick();
    cmp_en = 1'b1;
    check("reset_m_valid", 64'(MValid), 64'd0);
    check("reset_m", 64'(M), 64'd0);
    check("reset_m_sel", 64'(MSel), 64'd0);
    check("reset_in_ready", 64'(InReady), 64'd0);

    // First edge after release: round-robin grants channel 0
    Resetn = 1'b1;
    Mode = MODE_RR;
    InValid = 8'h01;
    set_ch(0, 16'hBEEF);
    MReady = 1'b1;
    #1 check("first_in_ready", 64'(InReady), 64'h01);
    tick();
    check("first_m", 64'(M), 64'hBEEF);
    check("first_m_sel", 64'(MSel), 64'd0);
    check("first_m_valid", 64'(MValid), 64'd1);

    // Mode 0 sweep
    Mode = MODE_SEL;
    InValid = 8'hFF;
    for (int k = 0; k < CH; k++) set_ch(k, 16'hA000 + 16'(k));
    for (int s = 0; s < CH; s++) begin
      S = SW'(s);
      tick();
      check("sweep_m", 64'(M), 64'hA000 + 64'(s));
      check("sweep_m_sel", 64'(MSel), 64'(s));
    end

    // Bring ptr to 0 through a transfer from channel 7, then fairness run
    Mode = MODE_RR;
    InValid = 8'h80;
    tick();
    check("wrap_m_sel", 64'(MSel), 64'd7);
    InValid = 8'hFF;
    for (int k = 0; k < CH; k++) cnt[k] = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i < 8) for (int k = 0; k < CH; k++) cnt[k] += int'(InReady[k]);
      tick();
      check("rr_m_sel", 64'(MSel), 64'(i % 8));
    end
    all_one = 1'b1;
    for (int k = 0; k < CH; k++) if (cnt[k] != 1) all_one = 1'b0;
    check("rr_one_pulse_each", 64'(all_one), 64'd1);

    // Sparse requests with ptr = 5
    InValid = 8'h10;
    tick();
    check("sparse_setup_sel", 64'(MSel), 64'd4);
    InValid = 8'b0000_0110;
    #1 check("sparse_in_ready_1", 64'(InReady), 64'h02);
    tick();
    check("sparse_m_sel_1", 64'(MSel), 64'd1);
    #1 check("sparse_in_ready_2", 64'(InReady), 64'h04);
    tick();
    check("sparse_m_sel_2", 64'(MSel), 64'd2);

    // Backpressure
    Mode = MODE_SEL;
    S = 3'd3;
    set_ch(3, 16'h0005);
    InValid = 8'hFF;
    tick();
    check("bp_load", 64'(M), 64'h0005);
    MReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      In = {$urandom, $urandom, $urandom, $urandom};
      S = SW'($urandom_range(CH - 1));
      Mode = 1'($urandom_range(1));
      #1 check("bp_in_ready", 64'(InReady), 64'd0);
      tick();
      check("bp_m", 64'(M), 64'h0005);
      check("bp_m_sel", 64'(MSel), 64'd3);
      check("bp_m_valid", 64'(MValid), 64'd1);
    end
    Mode = MODE_SEL;
    S = 3'd6;
    set_ch(6, 16'h6666);
    MReady = 1'b1;
    #1 check("bp_release_ready", 64'(InReady), 64'h40);
    tick();
    check("bp_release_m", 64'(M), 64'h6666);
    check("bp_release_sel", 64'(MSel), 64'd6);
    check("bp_release_valid", 64'(MValid), 64'd1);

    // Empty slot on no grant, data held
    InValid = 8'h00;
    tick();
    check("drain_valid", 64'(MValid), 64'd0);
    check("drain_m_hold", 64'(M), 64'h6666);
    check("drain_sel_hold", 64'(MSel), 64'd6);

    // Reset mid-transfer
    S = 3'd2;
    set_ch(2, 16'h1234);
    InValid = 8'hFF;
    tick();
    check("mid_load", 64'(M), 64'h1234);
    #1 Resetn = 1'b0;
    #1;
    check("mid_reset_valid", 64'(MValid), 64'd0);
    check("mid_reset_m", 64'(M), 64'd0);
    check("mid_reset_sel", 64'(MSel), 64'd0);
    check("mid_reset_ready", 64'(InReady), 64'h04);
    tick();
    Resetn = 1'b1;
    Mode = MODE_RR;
    InValid = 8'h01;
    set_ch(0, 16'h0C0C);
    #1 check("post_reset_ready", 64'(InReady), 64'h01);
    tick();
    check("post_reset_sel", 64'(MSel), 64'd0);
    check("post_reset_m", 64'(M), 64'h0C0C);

`ifdef MUX_ARB_NW_PARITY_EN
    Mode = MODE_SEL;
    S = 3'd3;
    InValid = 8'hFF;
    MReady = 1'b1;
    set_ch(3, 16'h0007);
    tick();
    check("parity_odd", 64'(MParity), 64'd1);
    set_ch(3, 16'h0003);
    tick();
    check("parity_even", 64'(MParity), 64'd0);
`endif

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      Resetn  = ($urandom_range(63) != 0);
      Mode    = 1'($urandom_range(1));
      S       = SW'($urandom_range(CH - 1));
      In      = {$urandom, $urandom, $urandom, $urandom};
      InValid = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      MReady  = ($urandom_range(3) != 0);
      tick();
    end
    Resetn = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
